alu_nbit_seq: RTL
=================

// Module: alu_nbit_seq
// PURPOSE
//  Parametrised, multi-cycle bit-sliced ALU (74181 function set). It is the WIDTH-generic successor of the 16-bit ripple ALU.
//  Operands are latched on start. SPC 4-bit slices are evaluated per clock, with the inter-slice carry and the group P/G
//  held in registers between cycles. Serves datapaths wider than 16 bits where a full combinational ripple misses timing.
// PARAMETERS
//  WIDTH  32  operand/result width; multiple of 4, >= 8
//  SPC    1   4-bit slices evaluated per cycle; must divide WIDTH/4
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  a      in   WIDTH  operand A, latched on accepted start
//  b      in   WIDTH  operand B, latched on accepted start
//  s      in   4      function select (74181 table), latched on start
//  m      in   1      1 = logic mode, 0 = arithmetic; latched on start
//  cin    in   1      carry-in, 74181 polarity (active-low: 1 = no carry); latched on start
//  busy   out  1      operation in progress
//  done   out  1      one-cycle pulse: o/cout/p/g/zero valid from this cycle
//  o      out  WIDTH  result F
//  cout   out  1      carry-out of top slice, same polarity as cin
//  p      out  1      word group propagate (AND of slice p)
//  g      out  1      word group generate
//  zero   out  1      1 when o == 0
// BEHAVIOUR
//  - Reset: busy=0, done=0, o=0, cout=1, p=0, g=0, zero=1. Slice index=0. Latched operands are cleared.
//  - FSM has two states: IDLE and RUN.
//    - IDLE & start: latch a, b, s, m, cin; carry_r<=cin; P_acc<=1; G_acc<=0; idx<=0; busy<=1 -> RUN.
//    - RUN: each cycle evaluate slices idx..idx+SPC-1, chaining carry combinationally from carry_r.
//      Write those nibbles of o. Then carry_r<=carry out; P_acc<=P_acc & AND(pp); G_acc<=gg_top | (pp_top & ...
//      ... G_acc), applied per slice low-to-high.
//    - RUN, last group (idx+SPC == WIDTH/4): cout, p, g, zero take their final values in the same edge.
//      busy<=0, done<=1 for exactly one cycle, then -> IDLE.
//  - Latency: start accepted at edge N -> done=1 after edge N+WIDTH/(4*SPC). Throughput: one op per latency+1 cycles.
//    A start is accepted the cycle done is high (back-to-back).
//  - start while busy=1 is ignored. The in-flight op is unaffected, with no queueing.
//    Input changes after acceptance have no effect.
//  - Outputs o/cout/p/g/zero hold their last completed values until the next done.
//    Partial nibbles of o are visible while busy and are undefined to consumers.
//  - In logic mode (m=1) carry is ignored by the F path. cout, p and g still report the slice equations.
//  - rst mid-operation aborts the op: next cycle is IDLE with reset values. No done is issued for the aborted op.
//  - rst and start high in the same cycle: rst wins and start is dropped.
//  - Arithmetic is modulo 2^WIDTH. Overflow is visible only via cout, and no signed overflow flag is produced.
// STRUCTURE
//  - Shared header alu_defs.vh: localparams for the 16 select codes (S_ADD=4'b1001, S_SUB=4'b0110, S_XOR=4'b0110 with m=1,
//    S_AND=4'b1011 with m=1, S_NOTA=4'b0000 with m=1), and reset values of cout/p/g.
//  - Sub-module: reuse the existing alu_4bit slice, instantiated SPC times via generate.
//    Operand nibbles are selected by a shift of the latched words (or an idx mux).
//  - Control: one FSM plus a $clog2(WIDTH/4)-bit slice counter.
// TESTING
//  - WIDTH=32,SPC=1: a=0x00001234,b=0x00000FFF,s=1001,m=0,cin=1 -> after 8 cycles done; o=0x00002233, cout=1, zero=0.
//  - a=0xFFFFFFFF,b=0x00000001,s=1001,m=0,cin=1 -> o=0x00000000, cout=0 (carry out), zero=1.
//    Carry must ripple across all 8 cycles.
//  - a=0x12345678,b=0x12345678,s=0110,m=0,cin=0 (A minus B) -> o=0, zero=1.
//    Same with m=1 (XOR) -> o=0, zero=1.
//  - Issue a start, then raise start again at cycles 2..7 with different operands -> ignored; first result correct.
//    A start on the done cycle is accepted and its done arrives 8 cycles later.
//  - rst asserted at cycle 4 of a run -> no done; outputs show reset values the next cycle.
//    A fresh op then completes normally.
//  - WIDTH=64,SPC=4: random a/b/s/m/cin vs. reference model -> done after 4 cycles; o/cout/p/g/zero match.

Source files
------------

// File: rtl/alu_nbit_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_nbit_seq_pkg
//  Purpose  : Shared select codes, flag reset values and FSM state type for
//             the multi-cycle bit-sliced 74181-style ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_nbit_seq_pkg;

  // Commonly used 74181 function selects (the m bit is noted where relevant)
  localparam logic [3:0] S_ADD  = 4'b1001;  // m=0: A plus B
  localparam logic [3:0] S_SUB  = 4'b0110;  // m=0: A minus B minus 1 (cin=0 gives A-B)
  localparam logic [3:0] S_XOR  = 4'b0110;  // m=1: A xor B
  localparam logic [3:0] S_AND  = 4'b1011;  // m=1: A and B
  localparam logic [3:0] S_NOTA = 4'b0000;  // m=1: not A

  // Output flag values after reset (cout uses active-low carry polarity)
  localparam logic COUT_RST = 1'b1;
  localparam logic P_RST    = 1'b0;
  localparam logic G_RST    = 1'b0;
  localparam logic ZERO_RST = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_nbit_seq_slice.sv
`default_nettype none
// ============================================================================
//  Module   : alu_nbit_seq_slice
//  Purpose  : One 4-bit 74181-style ALU slice. Carries are handled
//             active-high here; the top converts to/from 74181 polarity.
//  Revision : 1.0  initial release
// ============================================================================
module alu_nbit_seq_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       p,
  output logic       g
);

  logic [3:0] u;
  logic [3:0] v;
  logic [4:0] c;

  // Function is u + v + carry; v is always a subset of u, so u doubles as propagate
  always_comb begin
    u    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    v    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    c    = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = v[i] | (u[i] & c[i]);
    end
    f     = m ? ~(u ^ v) : (u ^ v ^ c[3:0]);
    p     = &u;
    g     = v[3] | (u[3] & v[2]) | (u[3] & u[2] & v[1]) | (u[3] & u[2] & u[1] & v[0]);
    c_out = c[4];
  end

endmodule
`default_nettype wire

// File: rtl/alu_nbit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_nbit_seq
//  Purpose  : WIDTH-generic multi-cycle 74181 ALU. SPC 4-bit slices are
//             evaluated per clock; inter-slice carry and group P/G are held
//             in registers between cycles.
//  Revision : 1.0  initial release
// ============================================================================
module alu_nbit_seq
  import alu_nbit_seq_pkg::*;
#(
  parameter int WIDTH = 32,   // multiple of 4, >= 8
  parameter int SPC   = 1     // must divide WIDTH/4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             p,
  output logic             g,
  output logic             zero
);

  localparam int NSL  = WIDTH / 4;
  localparam int IDXW = $clog2(NSL);
  localparam int GW   = 4 * SPC;
  localparam logic [WIDTH-1:0] GRP_MASK = WIDTH'({GW{1'b1}});

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       s_r;
  logic             m_r;
  logic             carry_r;   // 74181 polarity: 1 = no carry
  logic             p_acc;
  logic             g_acc;

  logic [GW-1:0]    f_grp;
  logic [SPC-1:0]   p_sl;
  logic [SPC-1:0]   g_sl;
  logic             c_top;
  logic [IDXW+1:0]  shamt;
  logic [WIDTH-1:0] o_nx;
  logic             p_nx;
  logic             g_nx;
  logic             last;

  // Latched operands are shifted down each cycle, so the slices always read the low GW bits
  for (genvar k = 0; k < SPC; k++) begin : g_slice
    logic c_in_k;
    logic c_out_k;
    if (k == 0) begin : g_first
      assign c_in_k = ~carry_r;
    end else begin : g_chain
      assign c_in_k = g_slice[k-1].c_out_k;
    end
    alu_nbit_seq_slice u_slice (
      .a     (a_r[4*k +: 4]),
      .b     (b_r[4*k +: 4]),
      .s     (s_r),
      .m     (m_r),
      .c_in  (c_in_k),
      .f     (f_grp[4*k +: 4]),
      .c_out (c_out_k),
      .p     (p_sl[k]),
      .g     (g_sl[k])
    );
  end

  assign c_top = g_slice[SPC-1].c_out_k;
  assign shamt = {idx, 2'b00};
  assign last  = ({1'b0, idx} + (IDXW+1)'(SPC)) == (IDXW+1)'(NSL);

  // Merge this cycle's nibbles into o and fold slice P/G into the word accumulators low-to-high
  always_comb begin
    o_nx = (o & ~(GRP_MASK << shamt)) | (WIDTH'(f_grp) << shamt);
    p_nx = p_acc;
    g_nx = g_acc;
    for (int k = 0; k < SPC; k++) begin
      p_nx = p_nx & p_sl[k];
      g_nx = g_sl[k] | (p_sl[k] & g_nx);
    end
  end

  // Control FSM: accept an op, step the slice window, publish final flags on the last group
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      m_r     <= 1'b0;
      carry_r <= COUT_RST;
      p_acc   <= 1'b0;
      g_acc   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      o       <= '0;
      cout    <= COUT_RST;
      p       <= P_RST;
      g       <= G_RST;
      zero    <= ZERO_RST;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            s_r     <= s;
            m_r     <= m;
            carry_r <= cin;
            p_acc   <= 1'b1;
            g_acc   <= 1'b0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          o       <= o_nx;
          a_r     <= a_r >> GW;
          b_r     <= b_r >> GW;
          carry_r <= ~c_top;
          p_acc   <= p_nx;
          g_acc   <= g_nx;
          if (last) begin
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= ~c_top;
            p     <= p_nx;
            g     <= g_nx;
            zero  <= (o_nx == '0);
            state <= ST_IDLE;
          end else begin
            idx <= idx + IDXW'(SPC);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
